serial_word_arbiter: RTL and testbench

Shares a single serial-to-parallel word assembler between `n_ports` one-bit serial sources. A round-robin arbiter grants one source at a time and holds that grant for a full `width`-bit word. The block shifts the granted source's bits into a word register and emits the word with the source index as a one-cycle pulse. It sits between the serial lane front-ends and the word-level consumer.

---
 rtl/serial_word_arbiter_pkg.sv | 33 +++
 rtl/serial_word_arbiter_if.sv | 32 +++
 rtl/rr_arbiter.sv | 22 ++
 rtl/serial_word_arbiter.sv | 116 +++++++++++
 tb/tb_serial_word_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_word_arbiter_pkg.sv
// rtl/serial_word_arbiter_pkg.sv - shared types and round-robin helper for serial_word_arbiter
// Contents:
//   state_t  : assembler FSM state (IDLE, BUSY)
//   rr_next  : first requester after 'last', wrapping modulo 'n'
package serial_word_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Rotating-priority search. The search starts one past 'last', so the
    // source that just finished a word is considered last. Requesters are
    // limited to 32, which bounds the unrolled loop.
    function automatic int unsigned rr_next(input logic [31:0] req,
                                            input int unsigned last,
                                            input int unsigned n);
        int unsigned idx;
        int unsigned cand;
        logic        found;
        idx   = 0;
        found = 1'b0;
        for (int unsigned k = 1; k <= 32; k++) begin
            cand = (last + k) % n;
            if (!found && (k <= n) && req[cand[4:0]]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/serial_word_arbiter_if.sv
// rtl/serial_word_arbiter_if.sv - serial lanes in, assembled words out
// Signals:
//   serial_valid/serial_data : per-source bit offer (from lane front-ends)
//   serial_ready             : per-source accept strobe
//   parallel_valid/data/port : one-cycle word strobe, word, source index
//   busy                     : a word is in progress
// Modports: master = lane/consumer side, slave = the assembler.
interface serial_word_arbiter_if #(
    parameter int n_ports = 4,
    parameter int width   = 8
);
    localparam int PW = $clog2(n_ports);

    logic [n_ports-1:0] serial_valid;
    logic [n_ports-1:0] serial_data;
    logic [n_ports-1:0] serial_ready;
    logic               parallel_valid;
    logic [width-1:0]   parallel_data;
    logic [PW-1:0]      parallel_port;
    logic               busy;

    modport master (
        output serial_valid, serial_data,
        input  serial_ready, parallel_valid, parallel_data, parallel_port, busy
    );

    modport slave (
        input  serial_valid, serial_data,
        output serial_ready, parallel_valid, parallel_data, parallel_port, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotating-priority pick
// Ports:
//   req        : request vector, one bit per source
//   last_grant : source that most recently completed a word
//   grant_idx  : first requester after last_grant (wrapping)
//   grant_any  : at least one request is present
module rr_arbiter
    import serial_word_arbiter_pkg::*;
#(
    parameter  int n_ports = 4,
    localparam int PW      = $clog2(n_ports)
) (
    input  logic [n_ports-1:0] req,
    input  logic [PW-1:0]      last_grant,
    output logic [PW-1:0]      grant_idx,
    output logic               grant_any
);

    assign grant_any = |req;
    assign grant_idx = PW'(rr_next(32'(req), 32'(last_grant), n_ports));

endmodule

// File: rtl/serial_word_arbiter.sv
// rtl/serial_word_arbiter.sv - round-robin shared serial-to-parallel word assembler
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : serial_word_arbiter_if.slave (serial lanes in, word strobe out)
// A grant is held for a full word; the granted lane's bits shift in LSB
// first and the finished word is emitted with its source index.
module serial_word_arbiter
    import serial_word_arbiter_pkg::*;
#(
    parameter int n_ports = 4,
    parameter int width   = 8
) (
    input logic                  clk,
    input logic                  rst,
    serial_word_arbiter_if.slave bus
);

    localparam int PW = $clog2(n_ports);
    localparam int CW = $clog2(width) + 1;

    state_t             r_state;
    state_t             w_next_state;
    logic [PW-1:0]      r_grant;
    logic [PW-1:0]      r_last_grant;
    logic [CW-1:0]      r_cnt;
    logic [width-1:0]   r_shift;
    logic               r_pvalid;
    logic [width-1:0]   r_pdata;
    logic [PW-1:0]      r_pport;

    logic [PW-1:0]      w_arb_idx;
    logic               w_arb_any;
    logic               w_accept;
    logic               w_word_done;
    logic [width-1:0]   w_shift_next;
    logic [n_ports-1:0] w_ready;

    rr_arbiter #(.n_ports(n_ports)) u_arb (
        .req        (bus.serial_valid),
        .last_grant (r_last_grant),
        .grant_idx  (w_arb_idx),
        .grant_any  (w_arb_any)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_word_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_any) w_next_state = BUSY;
            end
            BUSY: begin
                // Ready is only ever raised for the granted lane, so its
                // valid alone decides whether a bit moves this cycle.
                w_accept    = bus.serial_valid[r_grant];
                w_word_done = w_accept && (r_cnt == CW'(width - 1));
                if (w_word_done) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // New bits enter at the top, so the first bit ends up in bit 0.
    assign w_shift_next = {bus.serial_data[r_grant], r_shift[width-1:1]};

    // Ready decodes from registered state only; no valid-to-ready path.
    always_comb begin
        w_ready = '0;
        for (int i = 0; i < n_ports; i++) begin
            w_ready[i] = (r_state == BUSY) && (r_grant == PW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= '0;
            r_last_grant <= PW'(n_ports - 1);
            r_cnt        <= '0;
            r_shift      <= '0;
            r_pvalid     <= 1'b0;
            r_pdata      <= '0;
            r_pport      <= '0;
        end else begin
            r_pvalid <= 1'b0;
            if ((r_state == IDLE) && w_arb_any) begin
                r_grant <= w_arb_idx;
                r_cnt   <= '0;
            end
            if (w_accept) begin
                r_shift <= w_shift_next;
                r_cnt   <= r_cnt + CW'(1);
                if (w_word_done) begin
                    r_pvalid     <= 1'b1;
                    r_pdata      <= w_shift_next;
                    r_pport      <= r_grant;
                    r_last_grant <= r_grant;
                    r_cnt        <= '0;
                end
            end
        end
    end

    assign bus.serial_ready   = w_ready;
    assign bus.busy           = (r_state == BUSY);
    assign bus.parallel_valid = r_pvalid;
    assign bus.parallel_data  = r_pdata;
    assign bus.parallel_port  = r_pport;

endmodule

// File: tb/tb_serial_word_arbiter.sv
// tb/tb_serial_word_arbiter.sv - directed bench for serial_word_arbiter with a word-level model
module tb_serial_word_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_word_arbiter_if #(.n_ports(4), .width(8))  bus_a ();
    serial_word_arbiter_if #(.n_ports(2), .width(2))  bus_b ();
    serial_word_arbiter_if #(.n_ports(5), .width(16)) bus_c ();

    serial_word_arbiter #(.n_ports(4), .width(8))  dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    serial_word_arbiter #(.n_ports(2), .width(2))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    serial_word_arbiter #(.n_ports(5), .width(16)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- lane drivers for bus_a ----------------
    bit         q [4][$];
    int         sent [4];
    int         gap_after [4];
    int         gap_len [4];
    int         gap_left [4];
    logic [3:0] hs;

    task automatic load(input int p, input logic [7:0] w);
        for (int i = 0; i < 8; i++) q[p].push_back(w[i]);
    endtask

    task automatic drive_step();
        for (int p = 0; p < 4; p++) begin
            if (hs[p]) begin
                void'(q[p].pop_front());
                sent[p]++;
                if (sent[p] == gap_after[p]) gap_left[p] = gap_len[p];
            end
            bus_a.serial_valid[p] = (q[p].size() > 0) && (gap_left[p] == 0);
            bus_a.serial_data[p]  = (q[p].size() > 0) ? q[p][0] : 1'b0;
            if (gap_left[p] > 0) gap_left[p]--;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        hs = bus_a.serial_valid & bus_a.serial_ready;
        @(posedge clk);
        #1;
        drive_step();
    endtask

    // ---------------- observed word / grant log ----------------
    int         ev_cyc [$];
    int         ev_port [$];
    logic [7:0] ev_data [$];
    int         gr_cyc [$];
    int         gr_port [$];

    task automatic clear_drv();
        for (int p = 0; p < 4; p++) begin
            q[p].delete();
            sent[p]      = 0;
            gap_after[p] = -1;
            gap_len[p]   = 0;
            gap_left[p]  = 0;
        end
        hs = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_drv();
        drive_step();
        tick();
        rst = 1'b0;
        ev_cyc.delete(); ev_port.delete(); ev_data.delete();
        gr_cyc.delete(); gr_port.delete();
    endtask

    task automatic chk_ev(input string nm, input int i, input int port,
                          input logic [7:0] d, input int at);
        if (i >= ev_cyc.size()) begin
            chk({nm, "_present"}, ev_cyc.size(), i + 1);
        end else begin
            chk({nm, "_port"}, ev_port[i], port);
            chk({nm, "_data"}, ev_data[i], d);
            chk({nm, "_cycle"}, ev_cyc[i], at);
        end
    endtask

    // ---------------- word-level model of bus_a ----------------
    int         m_owner = -1;
    int         m_nbits = 0;
    int         m_last  = 3;
    logic [7:0] m_word  = '0;
    bit         m_pend  = 0;
    logic [7:0] m_pdata = '0;
    int         m_pport = 0;
    logic [7:0] m_hdata = '0;
    int         m_hport = 0;
    bit         rst_prev = 1;
    logic [3:0] prev_ready = '0;

    always @(negedge clk) begin
        logic [3:0] exp_ready;
        int         pick;
        bit         found;
        if (rst_prev) begin
            chk("rst_ready",  bus_a.serial_ready,   0);
            chk("rst_pvalid", bus_a.parallel_valid, 0);
            chk("rst_pdata",  bus_a.parallel_data,  0);
            chk("rst_pport",  bus_a.parallel_port,  0);
            chk("rst_busy",   bus_a.busy,           0);
            m_owner = -1; m_nbits = 0; m_last = 3;
            m_hdata = '0; m_hport = 0;
        end else begin
            exp_ready = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
            chk("ready",  bus_a.serial_ready,   exp_ready);
            chk("busy",   bus_a.busy,           m_owner >= 0);
            chk("pvalid", bus_a.parallel_valid, m_pend);
            if (m_pend) begin
                m_hdata = m_pdata;
                m_hport = m_pport;
            end
            chk("pdata", bus_a.parallel_data, m_hdata);
            chk("pport", bus_a.parallel_port, m_hport);
            if (bus_a.parallel_valid) begin
                ev_cyc.push_back(cyc);
                ev_port.push_back(int'(bus_a.parallel_port));
                ev_data.push_back(bus_a.parallel_data);
            end
            if ((bus_a.serial_ready != 0) && (prev_ready == 0)) begin
                for (int i = 0; i < 4; i++)
                    if (bus_a.serial_ready[i]) begin
                        gr_cyc.push_back(cyc);
                        gr_port.push_back(i);
                    end
            end
        end
        prev_ready = bus_a.serial_ready;
        m_pend = 0;
        if (!rst) begin
            if (m_owner < 0) begin
                found = 0;
                pick  = 0;
                for (int k = 1; k <= 4; k++) begin
                    if (!found && bus_a.serial_valid[(m_last + k) % 4]) begin
                        pick  = (m_last + k) % 4;
                        found = 1;
                    end
                end
                if (found) begin
                    m_owner = pick;
                    m_nbits = 0;
                end
            end else if (bus_a.serial_valid[m_owner]) begin
                m_word[m_nbits] = bus_a.serial_data[m_owner];
                m_nbits++;
                if (m_nbits == 8) begin
                    m_pend  = 1;
                    m_pdata = m_word;
                    m_pport = m_owner;
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
        rst_prev = rst;
    end

    // ---------------- stimulus ----------------
    int          req;
    int          got_rdy, got_pv, npv, bi;
    logic [31:0] got_data, got_port;
    logic [1:0]  wb;
    logic [15:0] wc;

    initial begin
        bus_b.serial_valid = '0; bus_b.serial_data = '0;
        bus_c.serial_valid = '0; bus_c.serial_data = '0;
        clear_drv();
        drive_step();
        @(posedge clk);
        #1;
        do_reset();

        chk("b_rst_ready",  bus_b.serial_ready,   0);
        chk("b_rst_pvalid", bus_b.parallel_valid, 0);
        chk("b_rst_pdata",  bus_b.parallel_data,  0);
        chk("b_rst_pport",  bus_b.parallel_port,  0);
        chk("b_rst_busy",   bus_b.busy,           0);
        chk("c_rst_ready",  bus_c.serial_ready,   0);
        chk("c_rst_pvalid", bus_c.parallel_valid, 0);
        chk("c_rst_pdata",  bus_c.parallel_data,  0);
        chk("c_rst_pport",  bus_c.parallel_port,  0);
        chk("c_rst_busy",   bus_c.busy,           0);

        // Single word from port 2: bits 1,0,1,0,0,1,0,1 -> 0xA5
        do_reset();
        load(2, 8'hA5);
        drive_step();
        req = cyc;
        repeat (14) tick();
        chk("p1_nwords", ev_cyc.size(), 1);
        chk_ev("p1", 0, 2, 8'hA5, req + 9);
        if (gr_cyc.size() == 0) chk("p1_grant_present", 0, 1);
        else begin
            chk("p1_grant_cycle", gr_cyc[0], req + 1);
            chk("p1_grant_port",  gr_port[0], 2);
        end

        // Contention between ports 0 and 3
        do_reset();
        load(0, 8'h11); load(0, 8'h22);
        load(3, 8'h33); load(3, 8'h44);
        drive_step();
        req = cyc;
        repeat (45) tick();
        chk("p2_nwords", ev_cyc.size(), 4);
        chk_ev("p2_w0", 0, 0, 8'h11, req + 9);
        chk_ev("p2_w1", 1, 3, 8'h33, req + 18);
        chk_ev("p2_w2", 2, 0, 8'h22, req + 27);
        chk_ev("p2_w3", 3, 3, 8'h44, req + 36);

        // Full round-robin, all four ports requesting
        do_reset();
        load(0, 8'h5A); load(0, 8'h0F);
        load(1, 8'h3C); load(2, 8'h96); load(3, 8'hE1);
        drive_step();
        req = cyc;
        repeat (50) tick();
        chk("p3_nwords", ev_cyc.size(), 5);
        chk_ev("p3_w0", 0, 0, 8'h5A, req + 9);
        chk_ev("p3_w1", 1, 1, 8'h3C, req + 18);
        chk_ev("p3_w2", 2, 2, 8'h96, req + 27);
        chk_ev("p3_w3", 3, 3, 8'hE1, req + 36);
        chk_ev("p3_w4", 4, 0, 8'h0F, req + 45);

        // Port 1 pauses 3 cycles after bit 4 while port 0 waits
        do_reset();
        load(1, 8'h6B);
        gap_after[1] = 4;
        gap_len[1]   = 3;
        load(0, 8'h81);
        gap_left[0]  = 2;
        drive_step();
        req = cyc;
        repeat (30) tick();
        chk("p4_nwords", ev_cyc.size(), 2);
        chk_ev("p4_w0", 0, 1, 8'h6B, req + 12);
        chk_ev("p4_w1", 1, 0, 8'h81, req + 21);

        // Reset after 5 bits of a word from port 1
        do_reset();
        load(1, 8'h3C);
        drive_step();
        for (int i = 0; i < 20 && sent[1] < 5; i++) tick();
        chk("p5_bits_before_rst", sent[1], 5);
        do_reset();
        repeat (4) tick();
        chk("p5_no_word", ev_cyc.size(), 0);
        load(1, 8'hD2);
        drive_step();
        req = cyc;
        repeat (14) tick();
        chk("p5_nwords", ev_cyc.size(), 1);
        chk_ev("p5", 0, 1, 8'hD2, req + 9);

        // n_ports=2, width=2: port 1 sends bits 1,0 -> word 2'b01
        wb = 2'b01;
        got_rdy = -1; got_pv = -1; npv = 0; got_data = '0; got_port = '0;
        for (int j = 0; j <= 6; j++) begin
            bi = (j == 0) ? 0 : ((j - 1 > 1) ? 1 : j - 1);
            bus_b.serial_valid = (j <= 2) ? 2'b10 : 2'b00;
            bus_b.serial_data  = (j <= 2) ? {wb[bi], 1'b0} : 2'b00;
            @(negedge clk);
            if (got_rdy < 0 && bus_b.serial_ready[1]) got_rdy = j;
            if (bus_b.parallel_valid) begin
                npv++;
                if (got_pv < 0) begin
                    got_pv   = j;
                    got_data = 32'(bus_b.parallel_data);
                    got_port = 32'(bus_b.parallel_port);
                end
            end
            @(posedge clk);
            #1;
        end
        chk("b_ready_lat", got_rdy, 1);
        chk("b_word_lat",  got_pv, 3);
        chk("b_nwords",    npv, 1);
        chk("b_data",      got_data, 32'h1);
        chk("b_port",      got_port, 1);

        // n_ports=5, width=16: port 3 sends 0xC3A5 LSB first
        wc = 16'hC3A5;
        got_rdy = -1; got_pv = -1; npv = 0; got_data = '0; got_port = '0;
        for (int j = 0; j <= 20; j++) begin
            bi = (j == 0) ? 0 : ((j - 1 > 15) ? 15 : j - 1);
            bus_c.serial_valid = (j <= 16) ? 5'b01000 : 5'b00000;
            bus_c.serial_data  = (j <= 16) ? {1'b0, wc[bi], 3'b000} : 5'b00000;
            @(negedge clk);
            if (got_rdy < 0 && bus_c.serial_ready[3]) got_rdy = j;
            if (bus_c.parallel_valid) begin
                npv++;
                if (got_pv < 0) begin
                    got_pv   = j;
                    got_data = 32'(bus_c.parallel_data);
                    got_port = 32'(bus_c.parallel_port);
                end
            end
            @(posedge clk);
            #1;
        end
        chk("c_ready_lat", got_rdy, 1);
        chk("c_word_lat",  got_pv, 17);
        chk("c_nwords",    npv, 1);
        chk("c_data",      got_data, 32'hC3A5);
        chk("c_port",      got_port, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
